alu_share_arbiter: RTL and testbench

Sequential arbiter that shares the single combinational ALU (arithmetic, logic, shift and compare sub-units selected by the 6-bit ALUFun code) between two requesters: port 0 (CPU execute path) and port 1 (auxiliary unit, e.g. interrupt/exception address or debug calculations). It grants one request at a time using round-robin priority, drives registered operands into the shared ALU, captures the result, and returns it with a one-cycle acknowledge. For compare operations it also reports a 1-bit compare flag.

---
 rtl/alu_share_arbiter.sv | 93 +++++++++
 tb/tb_alu_share_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Operands are registered at grant; result and a one-cycle ack come back two clocks later.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [5:0]       fun0,
    input  logic [5:0]       fun1,
    input  logic             sign0,
    input  logic             sign1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [5:0]       alu_fun,
    output logic             alu_sign,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,
    output logic [WIDTH-1:0] result,
    output logic             cmp_flag,
    output logic             ack0,
    output logic             ack1,
    output logic             gnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   prio;
    logic   grant_en;
    logic   grant_sel;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        grant_sel = prio;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_en  = 1'b1;
                    // A lone requester wins outright; the pointer only breaks ties.
                    grant_sel = (req0 && req1) ? prio : req1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_fun  <= '0;
            alu_sign <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            result   <= '0;
            cmp_flag <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            gnt      <= 1'b0;
            busy     <= 1'b0;
            prio     <= 1'b0;
        end else begin
            if (grant_en) begin
                alu_fun  <= grant_sel ? fun1  : fun0;
                alu_sign <= grant_sel ? sign1 : sign0;
                alu_a    <= grant_sel ? a1    : a0;
                alu_b    <= grant_sel ? b1    : b0;
                gnt      <= grant_sel;
            end
            if (state == EXEC) begin
                result   <= alu_s;
                cmp_flag <= (alu_fun[5:4] == 2'b11) && alu_s[0];
            end
            ack0 <= (state == EXEC) && !gnt;
            ack1 <= (state == EXEC) && gnt;
            busy <= (state_nxt != IDLE);
            // Pointer moves only on completed service, so aborted ops leave it alone.
            if (state == RESP) prio <= ~gnt;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: a stand-in ALU drives alu_s and a
// transaction-level model predicts the winner, operands, result and ack timing.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [5:0]  fun0, fun1;
    logic        sign0, sign1;
    logic [31:0] a0, b0, a1, b1;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] alu_a, alu_b, alu_s, result;
    logic        cmp_flag, ack0, ack1, gnt, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: tie-break pointer and the last granted drive values.
    logic        m_prio;
    logic [5:0]  m_fun;
    logic        m_sign;
    logic [31:0] m_a, m_b;

    logic [5:0] fun_tab [8] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                                6'b010110, 6'b100000, 6'b110011, 6'b110101};

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .fun0(fun0), .fun1(fun1),
        .sign0(sign0), .sign1(sign1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .alu_fun(alu_fun), .alu_sign(alu_sign), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .result(result), .cmp_flag(cmp_flag),
        .ack0(ack0), .ack1(ack1), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f[5:4])
            2'b00: return f[0] ? a - b : a + b;
            2'b01: begin
                if (f[3:0] == 4'b1000) return a & b;
                if (f[3:0] == 4'b1110) return a | b;
                if (f[3:0] == 4'b0110) return a ^ b;
                return a;
            end
            2'b10: begin
                if (f[1:0] == 2'b00) return b << a[4:0];
                if (f[1:0] == 2'b01) return b >> a[4:0];
                return b;
            end
            default: begin
                if (f[3:1] == 3'b001) return {31'b0, a == b};
                if (f[3:1] == 3'b000) return {31'b0, a != b};
                if (f[3:1] == 3'b010) return {31'b0, s ? ($signed(a) < $signed(b)) : (a < b)};
                return 32'b0;
            end
        endcase
    endfunction

    assign alu_s = alu_fn(alu_fun, alu_sign, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic new_op(input bit p, input logic [5:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        if (p) begin req1 = 1'b1; fun1 = f; sign1 = s; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; fun0 = f; sign0 = s; a0 = a; b0 = b; end
    endtask

    task automatic new_rand(input bit p);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        new_op(p, fun_tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), a, b);
    endtask

    task automatic model_reset();
        m_prio = 1'b0; m_fun = '0; m_sign = 1'b0; m_a = '0; m_b = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fun"}, alu_fun, 0);   chk({tag, "_sign"}, alu_sign, 0);
        chk({tag, "_a"}, alu_a, 0);       chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_result"}, result, 0); chk({tag, "_cmp"}, cmp_flag, 0);
        chk({tag, "_ack0"}, ack0, 0);     chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_gnt"}, gnt, 0);       chk({tag, "_busy"}, busy, 0);
    endtask

    // Entered at the falling edge of an idle cycle with requests already driven;
    // returns at the falling edge of the next idle cycle.
    task automatic slot(input bit scramble);
        bit          w;
        logic [31:0] er;
        logic        ecmp;
        chk("idle_busy", busy, 0);
        chk("idle_ack0", ack0, 0);
        chk("idle_ack1", ack1, 0);
        if (!req0 && !req1) begin
            @(posedge clk); @(negedge clk);
            chk("hold_busy", busy, 0);
            chk("hold_a", alu_a, m_a);
            chk("hold_b", alu_b, m_b);
            return;
        end
        w = (req0 && req1) ? m_prio : req1;
        m_fun = w ? fun1 : fun0;  m_sign = w ? sign1 : sign0;
        m_a   = w ? a1 : a0;      m_b    = w ? b1 : b0;
        er   = alu_fn(m_fun, m_sign, m_a, m_b);
        ecmp = (m_fun[5:4] == 2'b11) ? er[0] : 1'b0;
        @(posedge clk); @(negedge clk);
        chk("exec_busy", busy, 1);   chk("exec_gnt", gnt, w);
        chk("exec_ack0", ack0, 0);   chk("exec_ack1", ack1, 0);
        chk("exec_fun", alu_fun, m_fun); chk("exec_sign", alu_sign, m_sign);
        chk("exec_a", alu_a, m_a);   chk("exec_b", alu_b, m_b);
        if (scramble) begin
            if (w) begin a1 = a1 + 97; b1 = ~b1; fun1 = fun_tab[$urandom_range(0, 7)]; sign1 = ~sign1; end
            else   begin a0 = a0 + 97; b0 = ~b0; fun0 = fun_tab[$urandom_range(0, 7)]; sign0 = ~sign0; end
        end
        @(posedge clk); @(negedge clk);
        chk("resp_ack0", ack0, !w);  chk("resp_ack1", ack1, w);
        chk("resp_busy", busy, 1);   chk("resp_gnt", gnt, w);
        chk("resp_result", result, er);
        chk("resp_cmp", cmp_flag, ecmp);
        m_prio = !w;
        if (w) req1 = 1'b0; else req0 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk_all_zero("reset");
        reset = 1'b0;
    endtask

    initial begin
        req0 = 0; req1 = 0; fun0 = 0; fun1 = 0; sign0 = 0; sign1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        do_reset();

        // Single ADD, then equal / unequal compares on port 1.
        new_op(0, 6'b000000, 0, 32'd5, 32'd7);
        slot(0);
        chk("add_5_7_model", alu_fn(6'b000000, 0, 32'd5, 32'd7), 32'd12);
        new_op(1, 6'b110011, 0, 32'h1234, 32'h1234);
        slot(0);
        new_op(1, 6'b110011, 0, 32'h1234, 32'h1235);
        slot(0);

        // Operands changed during EXEC must not affect the result.
        new_op(0, 6'b000000, 0, 32'd3, 32'd4);
        slot(1);

        // Both held continuously after reset: grants alternate starting at 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (!req0) new_rand(0);
            if (!req1) new_rand(1);
            slot(0);
        end
        req0 = 0; req1 = 0;
        @(posedge clk); @(negedge clk);

        // Reset during EXEC of requester 1 aborts it without an ack.
        new_op(1, 6'b000000, 0, 32'd11, 32'd22);
        @(posedge clk); @(negedge clk);
        chk("abort_gnt", gnt, 1);
        chk("abort_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        model_reset();
        chk_all_zero("abort");
        reset = 1'b0;
        new_rand(0);
        slot(0);
        slot(0);

        // Requester 1 alone, re-requesting straight after each ack.
        for (int i = 0; i < 4; i++) begin
            new_rand(1);
            slot(0);
        end

        // Random mix of arrivals, holds and idle cycles.
        for (int i = 0; i < 300; i++) begin
            if (!req0 && $urandom_range(0, 1) == 1) new_rand(0);
            if (!req1 && $urandom_range(0, 1) == 1) new_rand(1);
            slot(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
